// File: rtl/permutation_ctrl.sv
// permutation_ctrl -- round sequencer for the ASCON permutation datapath.
//
// On an accepted start it walks the datapath through ROUNDS_A (mode 0, p^a)
// or ROUNDS_B (mode 1, p^b) rounds, ending at round index 11, then pulses
// done_o for one cycle. A start seen in the DONE cycle is accepted directly
// so permutations can run back to back with no idle bubble.
//
// Ports:
//   clock_i   single clock, rising edge
//   resetb_i  synchronous active-high reset
//   start_i   request one permutation (accepted only while ready_o=1)
//   mode_i    0 = p^a, 1 = p^b; sampled with an accepted start
//   ready_o   start_i is accepted this cycle
//   busy_o    rounds in progress
//   select_o  datapath input select: 0 = external state, 1 = fed-back state
//   round_o   datapath round index
//   en_o      datapath state register enable
//   done_o    one-cycle pulse, datapath output holds the permuted state
//
// All outputs decode registered state only; nothing combinational from inputs.
module permutation_ctrl #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic       select_o,
  output logic [3:0] round_o,
  output logic       en_o,
  output logic       done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // First round index for each mode; the last round is always 11.
  localparam logic [3:0] RND_A0   = 4'(12 - ROUNDS_A);
  localparam logic [3:0] RND_B0   = 4'(12 - ROUNDS_B);
  localparam logic [3:0] RND_LAST = 4'd11;

  state_e     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       first_q, first_d;

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state_q <= IDLE;
      rnd_q   <= 4'd0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    first_d = first_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = RUN;
          rnd_d   = mode_i ? RND_B0 : RND_A0;
          first_d = 1'b1;
        end else begin
          state_d = IDLE;
          rnd_d   = 4'd0;
          first_d = 1'b0;
        end
      end
      RUN: begin
        first_d = 1'b0;
        // >= also catches an illegal 12..15 count and ends the run rather
        // than letting the counter wrap.
        if (rnd_q >= RND_LAST) begin
          state_d = DONE;
          rnd_d   = 4'd0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        rnd_d   = 4'd0;
        first_d = 1'b0;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    ready_o  = 1'b1;
    busy_o   = 1'b0;
    en_o     = 1'b0;
    select_o = 1'b0;
    round_o  = 4'd0;
    done_o   = 1'b0;
    unique case (state_q)
      RUN: begin
        ready_o  = 1'b0;
        busy_o   = 1'b1;
        en_o     = 1'b1;
        round_o  = rnd_q;
        // First RUN cycle loads the external state, later cycles feed back.
        select_o = ~first_q;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_permutation_ctrl.sv
// Scoreboard bench for permutation_ctrl: each accepted start pushes the
// expected per-cycle round/select items and the done pulse, tagged with the
// cycle in which they must appear; the monitor pops them as the DUT
// produces them and expects idle outputs in every other cycle.
module tb_permutation_ctrl;

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b1;
  logic       start_i = 1'b0;
  logic       mode_i = 1'b0;
  logic       ready_o, busy_o, select_o, en_o, done_o;
  logic [3:0] round_o;

  permutation_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .ready_o (ready_o),
    .busy_o  (busy_o),
    .select_o(select_o),
    .round_o (round_o),
    .en_o    (en_o),
    .done_o  (done_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    bit         dn;
    int         cyc;
    logic [3:0] rnd;
    logic       sel;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_on = 1'b1;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected items for a start driven in cycle cyc (accepted at the next edge).
  task automatic push_exp(input logic m);
    int n;
    exp_t e;
    n = m ? 6 : 12;
    for (int i = 0; i < n; i++) begin
      e.dn  = 1'b0;
      e.cyc = cyc + 1 + i;
      e.rnd = 4'(12 - n + i);
      e.sel = (i != 0);
      sb.push_back(e);
    end
    e.dn  = 1'b1;
    e.cyc = cyc + n + 1;
    e.rnd = 4'd0;
    e.sel = 1'b0;
    sb.push_back(e);
  endtask

  // Driver actions happen just after the falling edge, clear of the monitor.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clock_i);
      #1;
    end
  endtask

  task automatic start_perm(input logic m);
    start_i = 1'b1;
    mode_i  = m;
    push_exp(m);
    step();
    start_i = 1'b0;
  endtask

  always @(negedge clock_i) begin
    if (mon_on) begin
      logic exp_en, exp_dn;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missed_item_cyc", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      exp_en = (sb.size() > 0) && (sb[0].cyc == cyc) && !sb[0].dn;
      exp_dn = (sb.size() > 0) && (sb[0].cyc == cyc) && sb[0].dn;
      chk("en",     en_o,    exp_en);
      chk("busy",   busy_o,  exp_en);
      chk("ready",  ready_o, !exp_en);
      chk("done",   done_o,  exp_dn);
      chk("round",  round_o, exp_en ? sb[0].rnd : 4'd0);
      chk("select", select_o, exp_en ? sb[0].sel : 1'b0);
      if (exp_en || exp_dn) void'(sb.pop_front());
    end
  end

  initial begin
    // Reset held for two cycles.
    resetb_i = 1'b1;
    step(2);
    resetb_i = 1'b0;
    step(2);

    // p^a, with mode_i wiggled mid-run (must have no effect).
    start_perm(1'b0);
    step(4);
    mode_i = 1'b1;
    step(4);
    mode_i = 1'b0;
    step(6);

    // p^b.
    start_perm(1'b1);
    step(9);

    // Start pulses during RUN cycles 3 and 11 are ignored.
    start_perm(1'b0);          // now in RUN cycle 1
    step(2);                   // RUN cycle 3
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(7);                   // RUN cycle 11
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(4);

    // Back-to-back: start held across DONE, mode switched in the DONE cycle.
    start_i = 1'b1;
    mode_i  = 1'b0;
    push_exp(1'b0);
    step(13);                  // DONE cycle of p^a
    mode_i = 1'b1;
    push_exp(1'b1);
    step();
    start_i = 1'b0;
    mode_i  = 1'b0;
    step(9);

    // Reset wins over a simultaneous start.
    resetb_i = 1'b1;
    start_i  = 1'b1;
    step();
    resetb_i = 1'b0;
    start_i  = 1'b0;
    step(3);

    // Reset at round 5 of p^a: no done, then p^b runs cleanly.
    start_perm(1'b0);          // RUN cycle 1 (round 0)
    step(5);                   // round 5 on the outputs
    resetb_i = 1'b1;
    sb.delete();
    step();
    resetb_i = 1'b0;
    step(14);
    start_perm(1'b1);
    step(9);

    mon_on = 1'b0;
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/permutation_ctrl.md
# permutation_ctrl

Round sequencer for the ASCON permutation datapath. On a start request it drives the datapath's `select_i`, `round_i` and a register-enable for exactly 12 rounds (p^a) or 6 rounds (p^b). It then pulses completion. It sits between the ASCON mode FSM (initialisation / associated data / plaintext / finalisation) and the `permutation` instance, and is the only block that sequences that instance.

## Interface
Parameters:
- `ROUNDS_A`, default 12: round count for p^a; round indices 12-ROUNDS_A..11.
- `ROUNDS_B`, default 6: round count for p^b; round indices 12-ROUNDS_B..11.

Ports:
- `clock_i`  in  1  single clock; all state updates on the rising edge.
- `resetb_i`  in  1  synchronous, active-high reset (1 = reset, sampled on the `clock_i` rising edge).
- `start_i`  in  1  request one permutation; accepted only when `ready_o`=1.
- `mode_i`  in  1  sampled with an accepted start: 0 = p^a (ROUNDS_A), 1 = p^b (ROUNDS_B).
- `ready_o`  out  1  controller can accept `start_i` this cycle.
- `busy_o`  out  1  rounds in progress.
- `select_o`  out  1  to datapath `select_i`: 0 = take external state, 1 = take fed-back state.
- `round_o`  out  4  to datapath `round_i`: current round index (constant index 0..11).
- `en_o`  out  1  datapath state register enable for this cycle.
- `done_o`  out  1  one-cycle pulse: datapath output holds the permuted state.

## Operation
- FSM states: IDLE, RUN, DONE. Registers: state, 4-bit round counter `rnd`, `first` flag.
- **IDLE**
  - Outputs: `ready_o`=1, `busy_o`=0, `en_o`=0, `select_o`=0, `round_o`=0, `done_o`=0.
  - On `start_i`=1: go to RUN with `rnd` = 12-ROUNDS_A (mode 0) or 12-ROUNDS_B (mode 1), and `first`=1.
- **RUN**
  - Outputs: `ready_o`=0, `busy_o`=1, `en_o`=1, `round_o`=`rnd`, `select_o`=~`first`.
  - Each cycle: `first`<=0.
  - If `rnd`==11, go to DONE with `rnd` cleared to 0; otherwise `rnd`<=`rnd`+1.
  - `start_i` is ignored in RUN; no queuing.
- **DONE**
  - Outputs: `done_o`=1, `ready_o`=1, `busy_o`=0, `en_o`=0, `round_o`=0, `select_o`=0.
  - On `start_i`=1: go directly to RUN, initialised as from IDLE (back-to-back, no idle bubble). Otherwise go to IDLE.
- `mode_i` is only sampled on an accepted start; changes during RUN have no effect.
- Width rule: `rnd` never exceeds 11 and never wraps. An illegal counter value (12..15) in RUN forces the next state to DONE.
- Reset: when `resetb_i`=1 at an edge, the next state is IDLE, `rnd`=0, `first`=0. This holds from any state, including mid-RUN; the aborted permutation produces no `done_o`.
- Reset has priority over `start_i` in the same cycle.

## Timing
- All outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Reset values of all outputs: `ready_o`=1, `busy_o`=0, `en_o`=0, `select_o`=0, `round_o`=0, `done_o`=0.
- Start accepted at edge k:
  - RUN spans cycles k+1 .. k+N, where N = 12 or 6.
  - `done_o` is high in cycle k+N+1.
  - Latency from start to `done_o` is N+1 cycles.
- `select_o`=0 only in cycle k+1 (loads the external state with round 12-N). It is 1 for the remaining N-1 RUN cycles.
- Back-to-back: a start in the DONE cycle k+N+1 gives the next RUN at k+N+2. Throughput is one permutation per N+1 cycles.

## Test plan
- **Reset:** hold `resetb_i`=1 for 2 cycles → all outputs at their reset values; `ready_o`=1.
- **p^a:** `start_i`=1, `mode_i`=0 for one cycle →
  - `round_o` = 0,1,…,11 on 12 consecutive cycles with `en_o`=1;
  - `select_o` = 0 then 1×11;
  - `done_o` high exactly on the 13th cycle after the start edge.
  - Check with the datapath: state 1fc9a149abfd3af5 / dbf3ecfb9b64a1c2 / 755af9d2d12f5d05 / 6654c154e6e248f1 / 169557420d2a6714 matches the golden p^a output.
- **p^b:** `start_i`=1, `mode_i`=1 → `round_o` = 6..11, `select_o` = 0,1,1,1,1,1, `done_o` on the 7th cycle.
- **Start while busy:** pulse `start_i` at RUN cycles 3 and 11 → ignored; round sequence unchanged; a single `done_o`.
- **Back-to-back:** `start_i` held high across DONE with `mode_i` switched 0→1 → p^a, `done_o`, then p^b RUN on the next cycle; `done_o`s 13 and 7 cycles apart.
- **Reset mid-run:** assert `resetb_i` at round 5 of p^a → IDLE on the next cycle, `en_o`=0, no `done_o`. A new p^b start then runs rounds 6..11 correctly.
